// File: rtl/pipeline_fwd.sv
// pipeline_fwd: 4-stage ALU pipeline (read, execute, write-back, store) with per-stage valid bits.
// Define PIPE_FWD_EN to compile in the stage-2 operand forwarding mux.
module pipeline_fwd #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        func,
    input  logic [MEM_AW-1:0] addr,
    output logic [DATA_W-1:0] z,
    output logic              z_valid,
    input  logic [MEM_AW-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_rdata
);

    localparam int NREG = 1 << REG_AW;
    localparam int NMEM = 1 << MEM_AW;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] mem  [NMEM];

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [REG_AW-1:0] s1_rd;
    logic [3:0]        s1_func;
    logic [MEM_AW-1:0] s1_addr;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_result;
    logic [REG_AW-1:0] s2_rd;
    logic [MEM_AW-1:0] s2_addr;

    logic              s3_valid;
    logic [MEM_AW-1:0] s3_addr;

`ifdef PIPE_FWD_EN
    logic [REG_AW-1:0] s1_rs1;
    logic [REG_AW-1:0] s1_rs2;
    logic [REG_AW-1:0] s3_rd;
`endif

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;

    // Stage 3 always holds its result in z, so z doubles as the stage-4 forwarding source.
    always_comb begin
        op_a = s1_a;
        op_b = s1_b;
`ifdef PIPE_FWD_EN
        if (s2_valid && s2_rd == s1_rs1)
            op_a = s2_result;
        else if (s3_valid && s3_rd == s1_rs1)
            op_a = z;
        if (s2_valid && s2_rd == s1_rs2)
            op_b = s2_result;
        else if (s3_valid && s3_rd == s1_rs2)
            op_b = z;
`endif
    end

    always_comb begin
        alu_result = '0;
        case (s1_func)
            4'b0000: alu_result = op_a + op_b;
            4'b0001: alu_result = op_a - op_b;
            4'b0010: alu_result = op_a * op_b;
            4'b0011: alu_result = op_a;
            4'b0100: alu_result = op_b;
            4'b0101: alu_result = ~op_a;
            4'b0110: alu_result = ~op_b;
            4'b0111: alu_result = op_a << 1;
            4'b1000: alu_result = op_b >> 1;
            4'b1001: alu_result = op_a >> 1;
            4'b1010: alu_result = op_b << 1;
            4'b1011: alu_result = op_a & op_b;
            4'b1100: alu_result = op_a | op_b;
            4'b1101: alu_result = op_a ^ op_b;
            4'b1110: alu_result = DATA_W'(s1_addr);
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            z_valid  <= 1'b0;
            z        <= '0;
        end else begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            z_valid  <= s2_valid;
            if (s2_valid)
                z <= s2_result;
        end
    end

    // Payload registers need no reset: every consumer is qualified by a valid bit.
    always_ff @(posedge clk) begin
        s1_a      <= regs[rs1];
        s1_b      <= regs[rs2];
        s1_rd     <= rd;
        s1_func   <= func;
        s1_addr   <= addr;
        s2_result <= alu_result;
        s2_rd     <= s1_rd;
        s2_addr   <= s1_addr;
        s3_addr   <= s2_addr;
`ifdef PIPE_FWD_EN
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s3_rd     <= s2_rd;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (s2_valid) begin
            regs[s2_rd] <= s2_result;
        end
    end

    always_ff @(posedge clk) begin
        if (s3_valid)
            mem[s3_addr] <= z;
    end

    assign mem_rdata = mem[mem_raddr];

endmodule
